pwm_peripheral: RTL and testbench

Consumes the five control registers written over SPI: output enables, PWM-mode enables and a shared duty cycle. It drives 16 output pins from these registers.
Each pin is either held low, driven static high, or driven by a common 8-bit PWM waveform.
The block sits directly downstream of the SPI register file and feeds the chip's dedicated outputs.
Duty updates are glitch-free: they take effect only at a PWM period boundary.

---
 rtl/pwm_pkg.sv | 22 ++
 rtl/pwm_timebase.sv | 33 +++
 rtl/pwm_peripheral.sv | 53 +++++
 tb/tb_pwm_peripheral.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared constants for the PWM output block and the SPI register file that feeds it.
package pwm_pkg;

  localparam int DUTY_W = 8;
  localparam logic [DUTY_W-1:0] CNT_MAX   = 8'hFF;
  localparam logic [DUTY_W-1:0] DUTY_FULL = 8'hFF;
  localparam int NUM_OUT_DEFAULT = 16;

  // SPI register map, shared with the register file
  localparam logic [7:0] ADDR_EN_OUT_7_0  = 8'h00;
  localparam logic [7:0] ADDR_EN_OUT_15_8 = 8'h01;
  localparam logic [7:0] ADDR_EN_PWM_7_0  = 8'h02;
  localparam logic [7:0] ADDR_EN_PWM_15_8 = 8'h03;
  localparam logic [7:0] ADDR_PWM_DUTY    = 8'h04;

  // Full-scale duty is forced high so 0xFF really means 100 % with no low slot.
  function automatic logic pwm_level(input logic [DUTY_W-1:0] cnt,
                                     input logic [DUTY_W-1:0] duty);
    return (duty == DUTY_FULL) || (cnt < duty);
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Prescaler plus 8-bit PWM counter; flags the clock edge where the period wraps.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int PRESCALE = 13
) (
  input  logic              clk,
  input  logic              rst,
  output logic [DUTY_W-1:0] pwm_cnt,
  output logic              wrap
);

  localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);

  logic [15:0] prescale_cnt;
  logic        tick;

  assign tick = (prescale_cnt == PRE_LAST);
  assign wrap = tick && (pwm_cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      prescale_cnt <= '0;
      pwm_cnt      <= '0;
    end else if (tick) begin
      prescale_cnt <= '0;
      pwm_cnt      <= pwm_cnt + 8'd1;
    end else begin
      prescale_cnt <= prescale_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/pwm_peripheral.sv
// Drives the output pins low, static high or from the shared PWM waveform,
// with the duty cycle only re-sampled at period boundaries.
module pwm_peripheral
  import pwm_pkg::*;
#(
  parameter int PRESCALE = 13,
  parameter int NUM_OUT  = NUM_OUT_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         en_reg_out_7_0,
  input  logic [7:0]         en_reg_out_15_8,
  input  logic [7:0]         en_reg_pwm_7_0,
  input  logic [7:0]         en_reg_pwm_15_8,
  input  logic [7:0]         pwm_duty_cycle,
  output logic [NUM_OUT-1:0] out,
  output logic               period_start
);

  logic [DUTY_W-1:0] pwm_cnt;
  logic [DUTY_W-1:0] duty_shadow;
  logic              wrap;
  logic              pwm_sig;
  logic [15:0]       en_out;
  logic [15:0]       en_pwm;

  assign en_out  = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm  = {en_reg_pwm_15_8, en_reg_pwm_7_0};
  assign pwm_sig = pwm_level(pwm_cnt, duty_shadow);

  pwm_timebase #(
    .PRESCALE(PRESCALE)
  ) u_timebase (
    .clk     (clk),
    .rst     (rst),
    .pwm_cnt (pwm_cnt),
    .wrap    (wrap)
  );

  // The register maps only cover 16 pins, so NUM_OUT must not exceed 16.
  always_ff @(posedge clk) begin
    if (rst) begin
      duty_shadow  <= '0;
      period_start <= 1'b0;
      out          <= '0;
    end else begin
      period_start <= wrap;
      if (wrap) duty_shadow <= pwm_duty_cycle;
      out <= en_out[NUM_OUT-1:0] & (~en_pwm[NUM_OUT-1:0] | {NUM_OUT{pwm_sig}});
    end
  end

endmodule

// File: tb/tb_pwm_peripheral.sv
// Randomised bench for pwm_peripheral, checked every cycle against a period-arithmetic model.
module tb_pwm_peripheral;

  localparam int P      = 13;
  localparam int PERIOD = 256 * P;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] en_out_v;
  logic [15:0] en_pwm_v;
  logic [7:0]  duty_v;
  logic [15:0] out;
  logic        period_start;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state: edges since reset and the duty latched for the current period
  int          m_n      = 0;
  logic [7:0]  m_shadow = 8'h00;
  logic [15:0] exp_out  = '0;
  logic        exp_ps   = 1'b0;

  always #5 clk = ~clk;

  pwm_peripheral #(
    .PRESCALE(P),
    .NUM_OUT (16)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .en_reg_out_7_0  (en_out_v[7:0]),
    .en_reg_out_15_8 (en_out_v[15:8]),
    .en_reg_pwm_7_0  (en_pwm_v[7:0]),
    .en_reg_pwm_15_8 (en_pwm_v[15:8]),
    .pwm_duty_cycle  (duty_v),
    .out             (out),
    .period_start    (period_start)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expected);
    vectors++;
    if (got !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [15:0] eo, input logic [15:0] ep,
                               input logic [7:0] d);
    rst      = r;
    en_out_v = eo;
    en_pwm_v = ep;
    duty_v   = d;
  endtask

  function automatic int modelCnt();
    return (m_n / P) % 256;
  endfunction

  // Predict outputs after the coming edge from the current inputs
  task automatic modelStep();
    logic pwm;
    if (rst) begin
      m_n      = 0;
      m_shadow = 8'h00;
      exp_out  = '0;
      exp_ps   = 1'b0;
    end else begin
      pwm = (m_shadow == 8'hFF) || (modelCnt() < int'(m_shadow));
      for (int i = 0; i < 16; i++)
        exp_out[i] = en_out_v[i] && (!en_pwm_v[i] || pwm);
      m_n++;
      exp_ps = (m_n % PERIOD) == 0;
      if (exp_ps) m_shadow = duty_v;
    end
  endtask

  task automatic runCycle();
    modelStep();
    @(posedge clk);
    @(negedge clk);
    checkOutput("out", {16'd0, out}, {16'd0, exp_out});
    checkOutput("period_start", {31'd0, period_start}, {31'd0, exp_ps});
  endtask

  task automatic waitPeriodStart(output int waited);
    waited = 0;
    do begin
      runCycle();
      waited++;
    end while (period_start !== 1'b1 && waited < 2 * PERIOD);
    checkOutput("ps_seen", {31'd0, period_start}, 32'd1);
  endtask

  // Counts high clocks on pin 0 (PWM) and pin 4 over one output period window
  task automatic measureWindow(input int exp_hi, input int chg_cnt, input logic [7:0] chg_duty);
    int hi0 = 0;
    int hi4 = 0;
    for (int i = 0; i < PERIOD; i++) begin
      if (chg_cnt >= 0 && modelCnt() == chg_cnt) duty_v = chg_duty;
      runCycle();
      hi0 += (out[0] === 1'b1) ? 1 : 0;
      hi4 += (out[4] === 1'b1) ? 1 : 0;
    end
    checkOutput("hi_time_pin0", hi0, exp_hi);
    if (en_out_v[4] && !en_pwm_v[4]) checkOutput("hi_time_pin4", hi4, PERIOD);
    checkOutput("window_end_ps", {31'd0, period_start}, 32'd1);
  endtask

  initial begin
    #(3_000_000);
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int w;
    int hi;
    int guard;

    applyStimulus(1'b1, 16'hFFFF, 16'hFFFF, 8'hFF);
    repeat (3) runCycle();

    applyStimulus(1'b0, 16'h00FF, 16'h0000, 8'h80);
    runCycle();
    checkOutput("static_on", {16'd0, out}, 32'h0000_00FF);
    applyStimulus(1'b0, 16'h0000, 16'h0000, 8'h80);
    runCycle();
    checkOutput("static_off", {16'd0, out}, 32'h0);
    waitPeriodStart(w);
    checkOutput("first_ps_latency", 2 + w, PERIOD);

    applyStimulus(1'b0, 16'hFFFF, 16'h0F0F, 8'h80);
    measureWindow(128 * P, -1, 8'h00);
    measureWindow(128 * P, -1, 8'h00);

    duty_v = 8'h00;
    measureWindow(128 * P, -1, 8'h00);
    measureWindow(0, -1, 8'h00);
    duty_v = 8'hFF;
    measureWindow(0, -1, 8'h00);
    measureWindow(PERIOD, -1, 8'h00);
    measureWindow(PERIOD, -1, 8'h00);

    duty_v = 8'h40;
    measureWindow(PERIOD, -1, 8'h00);
    measureWindow(64 * P, 10, 8'hC0);
    measureWindow(192 * P, -1, 8'h00);

    duty_v = 8'h80;
    measureWindow(192 * P, -1, 8'h00);
    guard = 0;
    while (modelCnt() != 100 && guard < PERIOD) begin
      runCycle();
      guard++;
    end
    checkOutput("reached_cnt100", guard < PERIOD, 1);
    rst = 1'b1;
    runCycle();
    checkOutput("rst_out", {16'd0, out}, 32'h0);
    rst = 1'b0;
    hi = 0;
    for (int i = 0; i < PERIOD; i++) begin
      runCycle();
      hi += (out[0] === 1'b1) ? 1 : 0;
    end
    checkOutput("post_rst_hi_pin0", hi, 0);
    checkOutput("post_rst_ps", {31'd0, period_start}, 32'd1);

    for (int s = 0; s < 20; s++) begin
      applyStimulus($urandom_range(0, 9) == 0, 16'($urandom), 16'($urandom), 8'($urandom));
      if (rst) begin
        runCycle();
        rst = 1'b0;
      end
      repeat ($urandom_range(1, 800)) runCycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
